// File: rtl/ef_apb_master.sv
// ef_apb_master: turns a valid/ready command stream into single APB3 transfers,
// one outstanding at a time, with an optional PREADY stall timeout.
module ef_apb_master #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_write,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          rsp_timeout,
   output logic          PSEL,
   output logic          PENABLE,
   output logic [AW-1:0] PADDR,
   output logic          PWRITE,
   output logic [DW-1:0] PWDATA,
   input  logic [DW-1:0] PRDATA,
   input  logic          PREADY,
   input  logic          PSLVERR
);

   localparam int            CW        = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
   localparam bit            TO_EN     = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state_q, state_d;
   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic          pwrite_q, pwrite_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_timeout_q, rsp_timeout_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   // Wait counter saturates at all-ones so a disabled timeout can never wrap.
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               paddr_d   = req_addr;
               pwrite_d  = req_write;
               pwdata_d  = req_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_inc;
               if (TO_EN && (cnt_inc == CNT_LIMIT)) begin
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  state_d       = RESP;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Acceptance depends on state only, so a requester may wait on req_ready.
   assign req_ready   = PRESETn && (state_q == IDLE);
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/ef_apb_master.md
Name: ef_apb_master

Overview:
- APB3 initiator (requester) that turns a simple valid/ready command interface into single APB transfers, one at a time.
- Drives EF_* APB peripherals such as EF_GPIO8_APB from a CPU-less controller, DMA-style sequencer or bench harness.
- Returns read data, slave error status and a stall-timeout flag on a valid/ready response interface.

Parameters:
- AW, 16, APB address width (PADDR and req_addr).
- DW, 32, APB data width (PWDATA, PRDATA, req_wdata, rsp_rdata).
- TIMEOUT, 255, maximum consecutive ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout.

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  synchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when high together with req_valid
req_addr  in  AW  byte address
req_write  in  1  1=write, 0=read
req_wdata  in  DW  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DW  read data (0 for writes and for aborted transfers)
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  AW  APB address
PWRITE  out  1  APB direction
PWDATA  out  DW  APB write data
PRDATA  in  DW  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset: PRESETn low at a PCLK rising edge gives:
  - state IDLE;
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
  - wait counter 0.
- req_ready = PRESETn and (state==IDLE). It is combinational from state only, never from req_valid.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid and req_ready, register req_addr to PADDR, req_write to PWRITE and req_wdata to PWDATA.
  - Set PSEL=1, PENABLE=0, and go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, clear the wait counter, and go to ACCESS.
- ACCESS, PREADY=1:
  - rsp_rdata = PRDATA if PWRITE=0, else 0.
  - rsp_err = PSLVERR, rsp_timeout = 0.
  - PSEL=0, PENABLE=0, rsp_valid=1, go to RESP.
- ACCESS, PREADY=0:
  - Increment the wait counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, abort: PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go to RESP.
  - PREADY high in the same cycle the counter reaches TIMEOUT counts as a normal completion; completion wins over timeout.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_rdata, rsp_err and rsp_timeout keep their last values until the next completion.
- PADDR, PWRITE and PWDATA are stable from SETUP to the end of ACCESS. After completion they hold their last values; they are not cleared.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1 and ignored otherwise.
- Latency, zero-wait slave with rsp_ready tied high:
  - request accepted at edge 0;
  - SETUP during cycle 1, ACCESS during cycle 2;
  - rsp_valid high during cycle 3;
  - IDLE (req_ready=1) during cycle 4.
  - Throughput is 1 transfer per 4 cycles minimum, plus wait states, plus response backpressure.
- Only one outstanding transfer. No request is accepted in SETUP, ACCESS or RESP.
- Reset mid-transfer: at the reset edge PSEL and PENABLE drop to 0 and any pending response is discarded (rsp_valid=0).
- Wait counter width is clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.
- Protocol checks:
  - PENABLE=1 implies PSEL=1.
  - PENABLE is never high in the first PSEL cycle.
  - PSEL is never deasserted in ACCESS while PREADY=0, except on timeout.

Test Plan:
1. Write path against EF_GPIO8_APB with PREADY tied to 1:
   - stimulus: write 0x0008=0xFF, then 0x0004=0xA5;
   - required: each write gives rsp_valid 3 cycles after acceptance with rsp_err=0; then io_out=0xA5 and io_oe=0xFF.
2. Read path:
   - stimulus: write 0x0008=0x00, set io_in=0xAB, read 0x0000;
   - required: rsp_rdata=0x000000AB, rsp_err=0, rsp_timeout=0.
3. Wait states:
   - stimulus: stub slave holds PREADY low for 3 ACCESS cycles, then returns PRDATA=0xDEADBEEF;
   - required: PSEL, PENABLE and PADDR are stable for 4 ACCESS cycles; rsp_rdata=0xDEADBEEF; rsp_valid is high 6 cycles after acceptance.
4. Slave error and backpressure:
   - stimulus: stub asserts PSLVERR with PREADY; rsp_ready is held low for 5 cycles;
   - required: rsp_err=1 and rsp_timeout=0; rsp_* stay stable and req_ready=0 until rsp_ready; IDLE is reached 1 cycle after the handshake.
5. Timeout:
   - stimulus: TIMEOUT=8 with PREADY stuck low;
   - required: PSEL=0 after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; a following transfer to a normal slave completes cleanly.
6. Reset mid-transfer:
   - stimulus: PRESETn pulled low during ACCESS;
   - required: at the next edge PSEL=0, PENABLE=0, rsp_valid=0, PADDR=0; req_ready=1 in the first cycle after PRESETn returns high.
